y86_alu_pipe: RTL

Y86_ALU_PIPE -- requirements
Module: y86_alu_pipe

---
 rtl/y86_alu_pipe.sv | 130 +++++++++++++
 1 files changed

// File: rtl/y86_alu_pipe.sv
// y86_alu_pipe -- single-stage registered Y86 integer ALU with a
// valid/ready handshake on both sides and a {ZF,SF,OF} condition-code register.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid / in_ready     upstream handshake (in_ready is combinational)
//   in_fun                  0=ADD 1=SUB 2=AND 3=XOR, 4..15 flagged as illegal
//   in_a, in_b              valA, valB (two's complement, WIDTH bits)
//   in_setcc                load cc from this operation when it is accepted
//   out_valid / out_ready   downstream handshake
//   out_result, out_err     registered result / illegal-function flag
//   cc                      condition codes {ZF,SF,OF}
//
// Results follow Y86 operand order: SUB is valB - valA.
module y86_alu_pipe #(
    parameter int          WIDTH    = 64,
    parameter logic [2:0]  CC_RESET = 3'b100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_fun,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_setcc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_err,
    output logic [2:0]       cc
);

    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] FUN_ADD = 4'd0;
    localparam logic [3:0] FUN_SUB = 4'd1;
    localparam logic [3:0] FUN_AND = 4'd2;
    localparam logic [3:0] FUN_XOR = 4'd3;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             err;
    } alu_rsp_t;

    // ------------------------------------------------------------------
    // Combinational ALU
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    alu_rsp_t         alu_rsp;
    logic             alu_of;
    logic             alu_zf;
    logic             alu_sf;

    always_comb begin
        sum     = in_b + in_a;
        diff    = in_b - in_a;
        alu_rsp = '0;
        alu_of  = 1'b0;
        unique case (in_fun)
            FUN_ADD: begin
                alu_rsp.result = sum;
                // Same-sign operands whose sum flips sign.
                alu_of = (in_a[MSB] == in_b[MSB]) && (sum[MSB] != in_b[MSB]);
            end
            FUN_SUB: begin
                alu_rsp.result = diff;
                // Opposite-sign operands where the difference leaves b's sign.
                alu_of = (in_a[MSB] != in_b[MSB]) && (diff[MSB] != in_b[MSB]);
            end
            FUN_AND: alu_rsp.result = in_b & in_a;
            FUN_XOR: alu_rsp.result = in_b ^ in_a;
            default: alu_rsp.err    = 1'b1;  // result stays zero
        endcase
        alu_zf = (alu_rsp.result == '0);
        alu_sf = alu_rsp.result[MSB];
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic out_valid_q, out_valid_d;
    logic out_err_q,   out_err_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [2:0]       cc_q, cc_d;
    logic             accept;

    // Ready is held low during reset so nothing offered then is taken.
    assign in_ready = rst_n && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_err_d    = out_err_q;
        cc_d         = cc_q;
        if (accept) begin
            // Covers the consume-and-load case: no bubble between results.
            out_valid_d  = 1'b1;
            out_result_d = alu_rsp.result;
            out_err_d    = alu_rsp.err;
            if (in_setcc && !alu_rsp.err)
                cc_d = {alu_zf, alu_sf, alu_of};
        end else if (out_ready) begin
            // Result consumed; data fields keep their last value.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_err_q    <= 1'b0;
            cc_q         <= CC_RESET;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_err_q    <= out_err_d;
            cc_q         <= cc_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_err    = out_err_q;
    assign cc         = cc_q;

endmodule
